// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder and its write log.
package dm_pkg;

  localparam int DM_WORDS_DEFAULT  = 3072;
  localparam int LOG_DEPTH_DEFAULT = 8;

  // One committed store: who wrote it, which word, and the word as it now sits in memory.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_log_entry_t;

  // Lane-by-lane merge of new write data over the old word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_log_fifo.sv
// Write-log FIFO with a registered head and a valid/ready pop side.
// A push while full is accepted only when the head is popped in the same cycle;
// otherwise the entry is dropped and the sticky overflow flag rises.
module dm_log_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = LOG_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  dm_log_entry_t push_entry,
  output logic          head_valid,
  input  logic          head_ready,
  output dm_log_entry_t head_entry,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dm_log_entry_t storage [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_after_pop;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          push_ok;
  dm_log_entry_t head_next;

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));

  // Next occupancy and next head; the freshly pushed entry becomes head only if nothing older survives the pop.
  always_comb begin
    pop           = head_valid && head_ready;
    push_ok       = push && (!full || pop);
    rd_next       = pop ? rd_ptr + PW'(1) : rd_ptr;
    occ_after_pop = count - CW'(pop);
    count_next    = occ_after_pop + CW'(push_ok);
    head_next     = '0;
    if (count_next == '0)         head_next = '0;
    else if (occ_after_pop == '0) head_next = push_entry;
    else                          head_next = storage[rd_next];
  end

  // Entry storage needs no reset: the head register is what the outside sees.
  always_ff @(posedge clk) begin
    if (push_ok) storage[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_entry <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_ptr     <= rd_next;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      count      <= count_next;
      head_entry <= head_next;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational read, byte-enable write on the edge,
// and a log of every committed write for an external checker.
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DM_WORDS  = DM_WORDS_DEFAULT,
  parameter int LOG_DEPTH = LOG_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        range_err
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0]   mem [DM_WORDS];
  logic [29:0]   word_index;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          wr_req;
  logic          wr_en;
  logic [31:0]   merged;
  logic          unused_addr_bits;
  dm_log_entry_t push_entry;
  dm_log_entry_t head_entry;

  assign word_index       = m_data_addr[31:2];
  assign mem_idx          = word_index[AW-1:0];
  assign in_range         = (word_index < 30'(DM_WORDS));
  assign wr_req           = (m_data_byteen != 4'b0000);
  assign wr_en            = wr_req && in_range;
  assign unused_addr_bits = ^m_data_addr[1:0];

  assign m_data_rdata = in_range ? mem[mem_idx] : '0;
  assign merged       = byte_merge(m_data_rdata, m_data_wdata, m_data_byteen);

  assign push_entry.pc   = m_inst_addr;
  assign push_entry.addr = {word_index, 2'b00};
  assign push_entry.data = merged;

  // Memory array: cleared on reset, merged word stored on an in-range write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[mem_idx] <= merged;
    end
  end

  // Sticky flag for writes that fall outside the memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     range_err <= 1'b0;
    else if (wr_req && !in_range)  range_err <= 1'b1;
  end

  dm_log_fifo #(
    .DEPTH(LOG_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_entry(push_entry),
    .head_valid(log_valid),
    .head_ready(log_ready),
    .head_entry(head_entry),
    .overflow  (log_overflow)
  );

  assign log_pc   = head_entry.pc;
  assign log_addr = head_entry.addr;
  assign log_data = head_entry.data;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with literal expectations plus
// a randomized run, all checked against a word-array/queue model of the memory and log.
module tb_data_mem_responder;

  localparam int WORDS = 3072;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_inst_addr = '0;
  logic        log_ready = 1'b0;
  logic [31:0] m_data_rdata;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic        range_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [31:0] model_mem [WORDS];
  logic [95:0] model_log [$];
  bit          model_ovf;
  bit          model_rerr;

  data_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_inst_addr  (m_inst_addr),
    .m_data_rdata (m_data_rdata),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_pc       (log_pc),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .range_err    (range_err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    model_log.delete();
    model_ovf  = 0;
    model_rerr = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr[31:2] < WORDS) return model_mem[addr[31:2]];
    return '0;
  endfunction

  // The model forgets everything the moment reset rises.
  always @(posedge reset) model_clear();

  // Model update on each edge: pop first, then a write either merges and logs, is dropped, or flags a range error.
  always @(posedge clk) begin
    logic [31:0] merged;
    logic [31:0] idx;
    if (!reset) begin
      if (model_log.size() != 0 && log_ready) void'(model_log.pop_front());
      if (m_data_byteen != 4'b0000) begin
        idx = {2'b00, m_data_addr[31:2]};
        if (idx < WORDS) begin
          merged = model_mem[idx];
          for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
          model_mem[idx] = merged;
          if (model_log.size() < DEPTH)
            model_log.push_back({m_inst_addr, m_data_addr[31:2], 2'b00, merged});
          else
            model_ovf = 1;
        end else begin
          model_rerr = 1;
        end
      end
    end
  end

  // Every cycle out of reset, all outputs are compared with the model away from the clock edge.
  always @(negedge clk) begin
    logic [95:0] head;
    if (chk_en && !reset) begin
      head = (model_log.size() != 0) ? model_log[0] : '0;
      checkOutput("rdata", m_data_rdata, model_read(m_data_addr));
      checkOutput("log_valid", {31'b0, log_valid}, {31'b0, model_log.size() != 0});
      checkOutput("log_pc", log_pc, head[95:64]);
      checkOutput("log_addr", log_addr, head[63:32]);
      checkOutput("log_data", log_data, head[31:0]);
      checkOutput("log_overflow", {31'b0, log_overflow}, {31'b0, model_ovf});
      checkOutput("range_err", {31'b0, range_err}, {31'b0, model_rerr});
    end
  end

  // One clock of stimulus; returns just after the falling edge so checks see settled outputs.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] byteen, input logic [31:0] pc, input logic ready);
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = byteen;
    m_inst_addr   = pc;
    log_ready     = ready;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int drained;
    logic [29:0] idx;
    int sel;

    model_clear();
    @(negedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1;

    // Reset state and reads of untouched words.
    m_data_addr = 32'h0;    #1; checkOutput("rst_rd_0", m_data_rdata, 32'h0);
    m_data_addr = 32'h10;   #1; checkOutput("rst_rd_10", m_data_rdata, 32'h0);
    m_data_addr = 32'h2FFC; #1; checkOutput("rst_rd_2ffc", m_data_rdata, 32'h0);
    checkOutput("rst_valid", {31'b0, log_valid}, 32'h0);
    checkOutput("rst_ovf", {31'b0, log_overflow}, 32'h0);
    checkOutput("rst_rerr", {31'b0, range_err}, 32'h0);

    // Full-word write, then a single-lane write to the same word.
    applyStimulus(32'h40, 32'h1234_5678, 4'b1111, 32'h3000, 1'b0);
    applyStimulus(32'h40, 32'h00AB_0000, 4'b0100, 32'h3004, 1'b0);
    m_data_byteen = 4'b0000;
    #1;
    checkOutput("raw_rd_40", m_data_rdata, 32'h12AB_5678);
    checkOutput("log0_pc", log_pc, 32'h3000);
    checkOutput("log0_addr", log_addr, 32'h40);
    checkOutput("log0_data", log_data, 32'h1234_5678);
    applyStimulus(32'h40, 32'h0, 4'b0000, 32'h0, 1'b1);
    checkOutput("log1_pc", log_pc, 32'h3004);
    checkOutput("log1_addr", log_addr, 32'h40);
    checkOutput("log1_data", log_data, 32'h12AB_5678);
    applyStimulus(32'h40, 32'h0, 4'b0000, 32'h0, 1'b1);
    checkOutput("log_empty", {31'b0, log_valid}, 32'h0);
    checkOutput("log_empty_data", log_data, 32'h0);

    // Nine writes with the consumer stalled: the ninth is dropped.
    for (int k = 0; k < 9; k++)
      applyStimulus(32'h100 + 4*k, 32'h1111_1111 * (k + 1), 4'b1111, 32'h4000 + 4*k, 1'b0);
    m_data_byteen = 4'b0000;
    checkOutput("ovf_set", {31'b0, log_overflow}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("ovf_drain_pc", log_pc, 32'h4000 + 4*k);
      checkOutput("ovf_drain_data", log_data, 32'h1111_1111 * (k + 1));
      applyStimulus(32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    end
    checkOutput("ovf_drained", {31'b0, log_valid}, 32'h0);

    // Full FIFO plus a simultaneous push and pop: nothing lost.
    pulse_reset();
    for (int k = 0; k < 8; k++)
      applyStimulus(32'h200 + 4*k, 32'hA5A5_0000 + k, 4'b1111, 32'h4100 + 4*k, 1'b0);
    applyStimulus(32'h220, 32'h5A5A_5A5A, 4'b1111, 32'h4120, 1'b1);
    checkOutput("full_pushpop_ovf", {31'b0, log_overflow}, 32'h0);
    checkOutput("full_pushpop_head", log_pc, 32'h4104);
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      if (!log_valid) break;
      drained++;
      applyStimulus(32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    end
    checkOutput("full_drain_count", drained, 32'd8);

    // Write just past the end of memory.
    applyStimulus(32'h3000, 32'hDEAD_BEEF, 4'b1111, 32'h5000, 1'b1);
    m_data_byteen = 4'b0000;
    #1;
    checkOutput("oor_rerr", {31'b0, range_err}, 32'h1);
    checkOutput("oor_no_log", {31'b0, log_valid}, 32'h0);
    checkOutput("oor_rd", m_data_rdata, 32'h0);

    // Randomized traffic concentrated on a few words near both ends of memory.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      idx = 30'($urandom_range(0, 15));
      else if (sel < 9) idx = 30'($urandom_range(WORDS - 4, WORDS - 1));
      else              idx = 30'($urandom_range(WORDS, WORDS + 40));
      applyStimulus({idx, 2'($urandom)}, $urandom,
                    ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom),
                    32'h6000 + 4*n, ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 10; i++) applyStimulus(32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    applyStimulus(32'h40, 32'hCAFE_F00D, 4'b1111, 32'h7000, 1'b0);
    for (int k = 1; k < 4; k++)
      applyStimulus(32'h300 + 4*k, 32'h0F0F_0000 + k, 4'b1111, 32'h7000 + 4*k, 1'b0);
    m_data_addr   = 32'h40;
    m_data_byteen = 4'b0000;
    log_ready     = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("pre_rst_valid", {31'b0, log_valid}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, log_valid}, 32'h0);
    checkOutput("async_rst_data", log_data, 32'h0);
    checkOutput("async_rst_ovf", {31'b0, log_overflow}, 32'h0);
    checkOutput("async_rst_rerr", {31'b0, range_err}, 32'h0);
    checkOutput("async_rst_rd_40", m_data_rdata, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(32'h40, 32'h0, 4'b0000, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
